// File: rtl/maxpool_2x2_if.sv
// Stream interface for maxpool_2x2: raster-order float32 samples in, pooled results out.
// The master drives the sample side; the slave (the pooling block) drives the result side.
interface maxpool_2x2_if;
  logic        input_valid;
  logic        i_sof;
  logic [31:0] data_in;
  logic        output_valid;
  logic [31:0] data_out;
  logic        o_sof;

  modport master (
    output input_valid, i_sof, data_in,
    input  output_valid, data_out, o_sof
  );

  modport slave (
    input  input_valid, i_sof, data_in,
    output output_valid, data_out, o_sof
  );
endinterface

// File: rtl/maxpool_2x2.sv
// 2x2 stride-2 float32 max pooling over a raster stream, with a half-width line buffer.
// Define MAXPOOL_SIGNED_CMP_EN for a full signed float compare; the default compares magnitudes only.
module maxpool_2x2 #(
  parameter int input_x = 4,
  parameter int input_y = 4
) (
  input  logic         clk,
  input  logic         rst,
  maxpool_2x2_if.slave bus
);
  localparam int CW = (input_x > 2) ? $clog2(input_x) : 1;
  localparam int RW = (input_y > 2) ? $clog2(input_y) : 1;
  localparam int LB = input_x / 2;
  localparam int LW = (LB > 1) ? $clog2(LB) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(input_x - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(input_y - 1);

  // True only when b strictly beats a, so ties always keep the earlier operand a.
  function automatic logic b_wins(input logic [31:0] a, input logic [31:0] b);
    logic r;
`ifdef MAXPOOL_SIGNED_CMP_EN
    if (a[31] != b[31]) begin
      if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) begin
        r = 1'b0;
      end else begin
        r = a[31];
      end
    end else if (a[31]) begin
      r = (b[30:0] < a[30:0]);
    end else begin
      r = (b[30:0] > a[30:0]);
    end
`else
    r = ((b & 32'h7FFF_FFFF) > (a & 32'h7FFF_FFFF));
`endif
    return r;
  endfunction

  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
    return b_wins(a, b) ? b : a;
  endfunction

  logic [CW-1:0] col_cnt_q, col_cnt_d, col_cur_s;
  logic [RW-1:0] row_cnt_q, row_cnt_d, row_cur_s;
  logic [31:0]   pair_q, pair_d, pair_max_s;
  logic [31:0]   linebuf_q [LB];
  logic          lb_we_s;
  logic [LW-1:0] lb_idx_s;
  logic [31:0]   lb_wdata_s;
  logic          output_valid_q, output_valid_d;
  logic          o_sof_q, o_sof_d;
  logic [31:0]   data_out_q, data_out_d;

  // Window position, counter advance, pair/line-buffer capture and result formation.
  always_comb begin
    col_cur_s      = bus.i_sof ? '0 : col_cnt_q;
    row_cur_s      = bus.i_sof ? '0 : row_cnt_q;
    lb_idx_s       = LW'(col_cur_s >> 1);
    pair_max_s     = fmax(pair_q, bus.data_in);
    col_cnt_d      = col_cnt_q;
    row_cnt_d      = row_cnt_q;
    pair_d         = pair_q;
    lb_we_s        = 1'b0;
    lb_wdata_s     = pair_max_s;
    output_valid_d = 1'b0;
    o_sof_d        = 1'b0;
    data_out_d     = 32'd0;
    if (bus.input_valid) begin
      if (col_cur_s == COL_LAST) begin
        col_cnt_d = '0;
        row_cnt_d = (row_cur_s == ROW_LAST) ? '0 : row_cur_s + RW'(1);
      end else begin
        col_cnt_d = col_cur_s + CW'(1);
        row_cnt_d = row_cur_s;
      end
      if (!col_cur_s[0]) begin
        pair_d = bus.data_in;
      end else if (!row_cur_s[0]) begin
        lb_we_s = 1'b1;
      end else begin
        output_valid_d = 1'b1;
        data_out_d     = fmax(linebuf_q[lb_idx_s], pair_max_s);
        o_sof_d        = (row_cur_s == RW'(1)) && (col_cur_s == CW'(1));
      end
    end else begin
      output_valid_d = 1'b0;
    end
  end

  // Counters, pair register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt_q      <= '0;
      row_cnt_q      <= '0;
      pair_q         <= 32'd0;
      output_valid_q <= 1'b0;
      o_sof_q        <= 1'b0;
      data_out_q     <= 32'd0;
    end else begin
      col_cnt_q      <= col_cnt_d;
      row_cnt_q      <= row_cnt_d;
      pair_q         <= pair_d;
      output_valid_q <= output_valid_d;
      o_sof_q        <= o_sof_d;
      data_out_q     <= data_out_d;
    end
  end

  // Line buffer is never reset: every entry is written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (lb_we_s) begin
      linebuf_q[lb_idx_s] <= lb_wdata_s;
    end
  end

  assign bus.output_valid = output_valid_q;
  assign bus.o_sof        = o_sof_q;
  assign bus.data_out     = data_out_q;
endmodule
